// File: rtl/irq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl_pkg
// Purpose  : Shared definitions for the interrupt source controller:
//            register addresses, FSM state encoding, CAUSE field layout and
//            a lowest-set-bit priority helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package irq_ctrl_pkg;

  // Register map (rd_addr / wr_addr)
  localparam logic [1:0] IRQC_MASK  = 2'd0;
  localparam logic [1:0] IRQC_EDGE  = 2'd1;
  localparam logic [1:0] IRQC_PEND  = 2'd2;
  localparam logic [1:0] IRQC_CAUSE = 2'd3;

  // CAUSE register: valid flag position; id lives in bits 4:0
  localparam int IRQC_CAUSE_VALID_BIT = 31;

  typedef enum logic [1:0] {
    IRQC_IDLE = 2'd0,
    IRQC_REQ  = 2'd1,
    IRQC_SRV  = 2'd2
  } irqc_state_e;

  // Returns {found, index} of the lowest set bit; index 0 when nothing set.
  // Scanning from the top down lets the lowest index overwrite last.
  function automatic logic [5:0] lowest_set(input logic [31:0] v);
    logic [5:0] r;
    r = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) r = {1'b1, 5'(i)};
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : irq_sync_edge
// Purpose  : Synchroniser chain for one asynchronous interrupt line plus a
//            rising-edge pulse derived from the synchronised level.
// Ports    : clk       - system clock
//            rst_n     - asynchronous active-low reset
//            i_async   - raw interrupt line
//            o_level   - synchronised level
//            o_rise    - one-cycle pulse on a synchronised 0->1 transition
// Revision : 1.0 - initial release
// ============================================================================
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl
// Purpose  : Interrupt source controller. Synchronises N_IRQ lines, keeps
//            per-line pending/mask/edge state, requests service from the
//            pipeline control FSM over the irq/iack handshake and latches the
//            serviced source into CAUSE.
// Ports    : clk         - system clock
//            rst_n       - asynchronous active-low reset
//            i_irq_in    - raw interrupt lines
//            i_iack      - acknowledge level (high from IRQ entry until RET)
//            o_irq       - interrupt request (high only in REQ)
//            i_wr_en     - register write strobe
//            i_wr_addr   - register select for write
//            i_wr_data   - write data
//            i_rd_addr   - register select for read
//            o_rd_data   - combinational read data
//            o_cause_id  - id of the source being serviced
// Revision : 1.0 - initial release
// ============================================================================
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N_IRQ       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] i_irq_in,
  input  logic             i_iack,
  output logic             o_irq,
  input  logic             i_wr_en,
  input  logic [1:0]       i_wr_addr,
  input  logic [31:0]      i_wr_data,
  input  logic [1:0]       i_rd_addr,
  output logic [31:0]      o_rd_data,
  output logic [4:0]       o_cause_id
);

  logic [N_IRQ-1:0] r_mask;
  logic [N_IRQ-1:0] r_edge;
  logic [N_IRQ-1:0] r_pend;
  logic             r_cause_valid;
  logic [4:0]       r_cause_id;
  logic             r_irq;
  irqc_state_e      r_state;

  logic [N_IRQ-1:0] w_level;
  logic [N_IRQ-1:0] w_rise;
  logic [N_IRQ-1:0] w_active;
  logic [N_IRQ-1:0] w_w1c;
  logic [N_IRQ-1:0] w_ack_clr;
  logic [N_IRQ-1:0] w_win_onehot;
  logic [5:0]       w_win;
  logic             w_any;
  logic [4:0]       w_win_id;
  logic             w_ack_take;
  logic             w_wr_data_unused;

  // Upper write-data bits beyond N_IRQ are intentionally discarded.
  assign w_wr_data_unused = ^i_wr_data;

  generate
    for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_line
      irq_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (i_irq_in[gi]),
        .o_level (w_level[gi]),
        .o_rise  (w_rise[gi])
      );
    end
  endgenerate

  assign w_active   = r_pend & r_mask;
  assign w_win      = lowest_set(32'(w_active));
  assign w_any      = w_win[5];
  assign w_win_id   = w_win[4:0];
  assign w_ack_take = (r_state == IRQC_REQ) && i_iack;

  always_comb begin
    w_win_onehot = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      w_win_onehot[i] = w_any && (w_win_id == 5'(i));
    end
  end

  assign w_w1c     = (i_wr_en && (i_wr_addr == IRQC_PEND)) ? i_wr_data[N_IRQ-1:0] : '0;
  // Taking the interrupt consumes the winner's edge event.
  assign w_ack_clr = w_ack_take ? (w_win_onehot & r_edge) : '0;

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask <= '0;
      r_edge <= '0;
    end else if (i_wr_en) begin
      if (i_wr_addr == IRQC_MASK) r_mask <= i_wr_data[N_IRQ-1:0];
      if (i_wr_addr == IRQC_EDGE) r_edge <= i_wr_data[N_IRQ-1:0];
    end
  end

  // Edge lines: sticky, cleared by W1C or acknowledge, a same-cycle rise wins.
  // Level lines: mirror the synchronised level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_edge & (w_rise | (r_pend & ~w_w1c & ~w_ack_clr)))
              | (~r_edge & w_level);
    end
  end

  // Request / service FSM with registered irq output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IRQC_IDLE;
      r_irq         <= 1'b0;
      r_cause_valid <= 1'b0;
      r_cause_id    <= '0;
    end else begin
      case (r_state)
        IRQC_IDLE: begin
          if (w_any && !i_iack) begin
            r_state <= IRQC_REQ;
            r_irq   <= 1'b1;
          end
        end
        IRQC_REQ: begin
          if (i_iack) begin
            r_state       <= IRQC_SRV;
            r_irq         <= 1'b0;
            r_cause_valid <= 1'b1;
            r_cause_id    <= w_win_id;
          end else if (!w_any) begin
            r_state <= IRQC_IDLE;
            r_irq   <= 1'b0;
          end
        end
        IRQC_SRV: begin
          if (!i_iack) begin
            r_state       <= IRQC_IDLE;
            r_cause_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= IRQC_IDLE;
          r_irq   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    o_rd_data = '0;
    case (i_rd_addr)
      IRQC_MASK:  o_rd_data = 32'(r_mask);
      IRQC_EDGE:  o_rd_data = 32'(r_edge);
      IRQC_PEND:  o_rd_data = 32'(r_pend);
      IRQC_CAUSE: begin
        o_rd_data[IRQC_CAUSE_VALID_BIT] = r_cause_valid;
        o_rd_data[4:0]                  = r_cause_id;
      end
      default:    o_rd_data = '0;
    endcase
  end

  assign o_irq      = r_irq;
  assign o_cause_id = r_cause_id;

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_ctrl
// Purpose  : Directed self-checking bench for irq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl;

  localparam int N_IRQ = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N_IRQ-1:0] irq_in = '0;
  logic             iack = 1'b0;
  logic             irq;
  logic             wr_en = 1'b0;
  logic [1:0]       wr_addr = '0;
  logic [31:0]      wr_data = '0;
  logic [1:0]       rd_addr = '0;
  logic [31:0]      rd_data;
  logic [4:0]       cause_id;

  int n_checks = 0;
  int n_fail   = 0;

  irq_ctrl #(
    .N_IRQ       (N_IRQ),
    .SYNC_STAGES (2)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_irq_in   (irq_in),
    .i_iack     (iack),
    .o_irq      (irq),
    .i_wr_en    (wr_en),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .i_rd_addr  (rd_addr),
    .o_rd_data  (rd_data),
    .o_cause_id (cause_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    rd_addr = a;
    #1;
    check(tag, rd_data, exp);
  endtask

  initial begin
    // ---------------- reset state ----------------
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    check_reg("rst_mask",  2'd0, 32'h0);
    check_reg("rst_edge",  2'd1, 32'h0);
    check_reg("rst_pend",  2'd2, 32'h0);
    check_reg("rst_cause", 2'd3, 32'h0);
    check("rst_irq",   32'(irq), 32'h0);
    check("rst_cid",   32'(cause_id), 32'h0);

    // ---------------- single edge source, line 2 ----------------
    wr(2'd0, 32'h04);
    wr(2'd1, 32'h04);
    irq_in[2] = 1'b1;
    step();
    irq_in[2] = 1'b0;
    steps(2);
    check("e2_irq_early", 32'(irq), 32'h0);
    check_reg("e2_pend_set", 2'd2, 32'h04);
    step();
    check("e2_irq_high", 32'(irq), 32'h1);
    iack = 1'b1;
    step();
    check("e2_irq_srv", 32'(irq), 32'h0);
    check_reg("e2_cause_v", 2'd3, 32'h8000_0002);
    check_reg("e2_pend_clr", 2'd2, 32'h0);
    iack = 1'b0;
    step();
    check_reg("e2_cause_ret", 2'd3, 32'h0000_0002);
    check("e2_cid_hold", 32'(cause_id), 32'h2);

    // ---------------- priority: lines 5 and 1 together ----------------
    wr(2'd0, 32'hFFFF_FFFF);
    check_reg("mask_upper_ign", 2'd0, 32'h0000_00FF);
    wr(2'd1, 32'h0000_00FF);
    irq_in[5] = 1'b1;
    irq_in[1] = 1'b1;
    step();
    irq_in = '0;
    steps(3);
    check("pri_irq", 32'(irq), 32'h1);
    check_reg("pri_pend", 2'd2, 32'h22);
    iack = 1'b1;
    step();
    check("pri_cid1", 32'(cause_id), 32'h1);
    check_reg("pri_pend_left", 2'd2, 32'h20);
    iack = 1'b0;
    step();
    check("pri_idle_gap", 32'(irq), 32'h0);
    step();
    check("pri_rereq", 32'(irq), 32'h1);
    iack = 1'b1;
    step();
    check("pri_cid5", 32'(cause_id), 32'h5);
    check_reg("pri_pend_empty", 2'd2, 32'h0);
    iack = 1'b0;
    step();

    // ---------------- level source, line 0 ----------------
    wr(2'd1, 32'h00);
    wr(2'd0, 32'h01);
    irq_in[0] = 1'b1;
    steps(4);
    check("lvl_irq", 32'(irq), 32'h1);
    iack = 1'b1;
    step();
    check_reg("lvl_pend_srv", 2'd2, 32'h01);
    check_reg("lvl_cause", 2'd3, 32'h8000_0000);
    wr(2'd2, 32'h01);
    check_reg("lvl_w1c_noeff", 2'd2, 32'h01);
    iack = 1'b0;
    step();
    check("lvl_idle_gap", 32'(irq), 32'h0);
    step();
    check("lvl_rereq", 32'(irq), 32'h1);
    irq_in[0] = 1'b0;
    steps(4);
    check("lvl_withdraw", 32'(irq), 32'h0);
    check_reg("lvl_pend_zero", 2'd2, 32'h0);
    steps(3);
    check("lvl_no_req", 32'(irq), 32'h0);

    // ---------------- mask removed while in REQ ----------------
    wr(2'd1, 32'h08);
    wr(2'd0, 32'h08);
    irq_in[3] = 1'b1;
    step();
    irq_in[3] = 1'b0;
    steps(3);
    check("msk_irq", 32'(irq), 32'h1);
    wr(2'd0, 32'h00);
    step();
    check("msk_drop", 32'(irq), 32'h0);
    check_reg("msk_pend_kept", 2'd2, 32'h08);

    // ---------------- W1C colliding with a new edge ----------------
    irq_in[3] = 1'b1;
    steps(2);
    wr(2'd2, 32'h08);
    check_reg("w1c_set_wins", 2'd2, 32'h08);
    irq_in[3] = 1'b0;
    steps(3);
    wr(2'd2, 32'h08);
    check_reg("w1c_clears", 2'd2, 32'h0);

    // ---------------- asynchronous reset mid-service ----------------
    wr(2'd0, 32'h08);
    irq_in[3] = 1'b1;
    step();
    irq_in[3] = 1'b0;
    steps(3);
    iack = 1'b1;
    step();
    check_reg("ar_cause_v", 2'd3, 32'h8000_0003);
    #2;
    rst_n = 1'b0;
    iack  = 1'b0;
    #1;
    check("ar_irq", 32'(irq), 32'h0);
    check_reg("ar_cause", 2'd3, 32'h0);
    check_reg("ar_mask", 2'd0, 32'h0);
    check("ar_cid", 32'(cause_id), 32'h0);
    step();
    rst_n = 1'b1;
    steps(2);
    check("ar_idle", 32'(irq), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
